// File: rtl/fft_input_reorder.sv
// fft_input_reorder: input stage ahead of the FFT core.
// Collects natural-order 16-bit complex samples into N = 2^LOG2N point frames
// using a ping-pong pair of banks. Each frame is replayed in bit-reversed
// index order as a sign-extended 32-bit complex stream, with tlast on the
// final beat.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   s_data   {re[15:0], im[15:0]} two's complement input sample
//   s_valid  input sample valid
//   s_ready  block can accept an input sample (registered)
//   m_axis   {re[31:0], im[31:0], tlast} output beat (registered)
//   m_valid  output beat valid (registered)
//   m_ready  downstream accepts the output beat

package fft_input_reorder_pkg;
    localparam int unsigned SAMPLE_IN_W = 32;
    localparam int unsigned AXIS_W      = 65;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } sample_t_int;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } sample_t;

    typedef struct packed {
        sample_t tdata;
        logic    tlast;
    } axis_t;
endpackage

module fft_input_reorder
    import fft_input_reorder_pkg::*;
#(
    parameter int unsigned LOG2N = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_IN_W-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [AXIS_W-1:0]      m_axis,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int unsigned N = 1 << LOG2N;
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = x[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] x);
        return {{16{x[15]}}, x};
    endfunction

    // Both banks share one array; the top address bit selects the bank.
    logic [SAMPLE_IN_W-1:0] mem [2*N];

    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             rd_pend_q, rd_last_q, rd_last_d;
    sample_t_int      rd_data_q;
    axis_t            ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             s_ready_d, m_valid_d;

    logic             wr_fire, rd_fire, pop, push, rd_avail, rd_space;
    axis_t            rd_beat;

    // Next-state logic for bank states, pointers and the 2-entry output stage.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_last_d = rd_last_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        cnt_d     = cnt_q;

        wr_fire  = s_valid & s_ready;
        pop      = m_valid & m_ready;
        push     = rd_pend_q;
        rd_avail = (bank_q[rd_bank_q] == FULL) || (bank_q[rd_bank_q] == DRAINING);
        // Fetch only if the beat in flight plus this one still fit after any pop.
        rd_space = (3'(cnt_q) + 3'(rd_pend_q)) < (3'd2 + 3'(pop));
        rd_fire  = rd_avail & rd_space;

        rd_beat.tdata.re = sext16(rd_data_q.re);
        rd_beat.tdata.im = sext16(rd_data_q.im);
        rd_beat.tlast    = rd_last_q;

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_cnt_q == CNT_LAST) begin
                bank_d[wr_bank_q] = FULL;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                bank_d[wr_bank_q] = FILLING;
            end
        end

        // The bank's storage is free once its last word has been fetched; the
        // remaining beats of the frame live in the read register and skid stage.
        // Releasing here keeps back-to-back frames free of input stalls.
        if (rd_fire) begin
            rd_cnt_d  = rd_cnt_q + LOG2N'(1);
            rd_last_d = (rd_cnt_q == CNT_LAST);
            if (rd_cnt_q == CNT_LAST) begin
                bank_d[rd_bank_q] = EMPTY;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                bank_d[rd_bank_q] = DRAINING;
            end
        end

        // Output stage: ent0 is the presented beat, ent1 the skid entry.
        if (push && !pop) begin
            if (cnt_q == 2'd0) begin
                ent0_d = rd_beat;
            end else begin
                ent1_d = rd_beat;
            end
            cnt_d = cnt_q + 2'd1;
        end else if (!push && pop) begin
            ent0_d = ent1_q;
            cnt_d  = cnt_q - 2'd1;
        end else if (push && pop) begin
            if (cnt_q == 2'd1) begin
                ent0_d = rd_beat;
            end else begin
                ent0_d = ent1_q;
                ent1_d = rd_beat;
            end
        end

        s_ready_d = (bank_d[wr_bank_d] == EMPTY) || (bank_d[wr_bank_d] == FILLING);
        m_valid_d = (cnt_d != 2'd0);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0] <= EMPTY;
            bank_q[1] <= EMPTY;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
            ent0_q    <= '0;
            ent1_q    <= '0;
            cnt_q     <= 2'd0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_pend_q <= rd_fire;
            rd_last_q <= rd_last_d;
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            cnt_q     <= cnt_d;
            s_ready   <= s_ready_d;
            m_valid   <= m_valid_d;
        end
    end

    // Sample storage and registered bit-reversed read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_q, wr_cnt_q}] <= s_data;
        end
        if (rd_fire) begin
            rd_data_q <= mem[{rd_bank_q, bit_rev(rd_cnt_q)}];
        end
    end

    assign m_axis = ent0_q;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Testbench for fft_input_reorder with LOG2N = 3 (8-point frames).
// Directed table vectors plus random traffic checked against a frame model.
module tb_fft_input_reorder;

    localparam int unsigned LOG2N = 3;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [64:0] m_axis;
    logic        m_valid;
    logic        m_ready;

    always #5 clk = ~clk;

    fft_input_reorder #(.LOG2N(LOG2N)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_axis  (m_axis),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model state.
    logic [31:0] frame_buf [N];
    int          fill = 0;
    logic [64:0] exp_q [$];
    int          out_total = 0;
    int          in_total = 0;
    bit          prev_stall = 0;
    logic [64:0] prev_axis;
    int          win_cnt = 0;
    int          win_first = 0;
    int          win_last = 0;
    int          stall_cycles = 0;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [31:0] exp_re;
        logic [31:0] exp_im;
        logic        exp_last;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int rev_idx(input int i);
        int r = 0;
        int x = i;
        for (int k = 0; k < int'(LOG2N); k++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [64:0] expect_beat(input logic [31:0] smp, input bit last);
        return {{16{smp[31]}}, smp[31:16], {16{smp[15]}}, smp[15:0], last};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: scoreboard, stall stability, input capture into the frame model.
    always @(negedge clk) begin
        if (rst) begin
            fill = 0;
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 65'(m_valid), 65'd1);
                check("stall_hold", m_axis, prev_axis);
            end
            prev_stall = m_valid && !m_ready;
            prev_axis  = m_axis;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 65'(m_valid), 65'd0);
                end else begin
                    check("scoreboard", m_axis, exp_q.pop_front());
                end
                out_total++;
                if (win_cnt == 0) win_first = cyc;
                win_last = cyc;
                win_cnt++;
            end
            if (s_valid && s_ready) begin
                frame_buf[fill] = s_data;
                fill++;
                in_total++;
                if (fill == N) begin
                    for (int k = 0; k < N; k++) begin
                        exp_q.push_back(expect_beat(frame_buf[rev_idx(k)], k == N - 1));
                    end
                    fill = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and hold it until accepted (bounded).
    task automatic send(input logic [15:0] re, input logic [15:0] im);
        int  t = 0;
        bit  acc = 0;
        s_data  = {re, im};
        s_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (s_ready) acc = 1;
            else stall_cycles++;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 2000) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: s_ready stayed %b for %0d cycles", s_ready, t);
                s_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || m_valid) && t < budget) begin
            step();
            t++;
        end
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    bit done;
    int base;
    int base_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;

        // Frame 0: bit-reverse order; frame 1: sign extension.
        tbl[0]  = '{16'h0000, 16'hFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[1]  = '{16'h0001, 16'hFFFE, 32'h00000004, 32'hFFFFFFFB, 1'b0};
        tbl[2]  = '{16'h0002, 16'hFFFD, 32'h00000002, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{16'h0003, 16'hFFFC, 32'h00000006, 32'hFFFFFFF9, 1'b0};
        tbl[4]  = '{16'h0004, 16'hFFFB, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        tbl[5]  = '{16'h0005, 16'hFFFA, 32'h00000005, 32'hFFFFFFFA, 1'b0};
        tbl[6]  = '{16'h0006, 16'hFFF9, 32'h00000003, 32'hFFFFFFFC, 1'b0};
        tbl[7]  = '{16'h0007, 16'hFFF8, 32'h00000007, 32'hFFFFFFF8, 1'b1};
        tbl[8]  = '{16'h8000, 16'h7FFF, 32'hFFFF8000, 32'h00007FFF, 1'b0};
        tbl[9]  = '{16'h7FFF, 16'h8000, 32'h00001234, 32'hFFFFABCD, 1'b0};
        tbl[10] = '{16'h0001, 16'hFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{16'hFFFE, 16'h0000, 32'h000000FF, 32'hFFFFFF01, 1'b0};
        tbl[12] = '{16'h1234, 16'hABCD, 32'h00007FFF, 32'hFFFF8000, 1'b0};
        tbl[13] = '{16'h8001, 16'h7FFE, 32'hFFFF8001, 32'h00007FFE, 1'b0};
        tbl[14] = '{16'h00FF, 16'hFF01, 32'hFFFFFFFE, 32'h00000000, 1'b0};
        tbl[15] = '{16'hFF00, 16'h0100, 32'hFFFFFF00, 32'h00000100, 1'b1};

        // Reset state.
        repeat (3) step();
        check("rst_s_ready", 65'(s_ready), 65'd0);
        check("rst_m_valid", 65'(m_valid), 65'd0);
        check("rst_m_axis", m_axis, 65'd0);
        #2 rst = 1'b0;
        step();
        check("post_rst_s_ready", 65'(s_ready), 65'd1);

        // Table frames: latency, order, sign extension, tlast.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) send(tbl[f*N+i].re, tbl[f*N+i].im);
            s_valid = 1'b0;
            check("latency_c0", 65'(m_valid), 65'd0);
            step();
            check("latency_c1", 65'(m_valid), 65'd0);
            step();
            for (int k = 0; k < N; k++) begin
                check("tbl_valid", 65'(m_valid), 65'd1);
                check("tbl_beat", m_axis,
                      {tbl[f*N+k].exp_re, tbl[f*N+k].exp_im, tbl[f*N+k].exp_last});
                step();
            end
            check("tbl_idle", 65'(m_valid), 65'd0);
            repeat (2) step();
        end

        // Streaming: 4 back-to-back frames, no bubbles in or out.
        stall_cycles = 0;
        win_cnt = 0;
        for (int i = 0; i < 4 * N; i++) send(16'($urandom), 16'($urandom));
        s_valid = 1'b0;
        wait_drain(200);
        check_int("stream_in_stalls", stall_cycles, 0);
        check_int("stream_out_count", win_cnt, 4 * N);
        check_int("stream_out_span", win_last - win_first, 4 * N - 1);

        // Random traffic: 10 frames, random input gaps and 50% m_ready.
        base = out_total;
        done = 0;
        fork
            begin
                for (int i = 0; i < 10 * N; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        s_valid = 1'b0;
                        step();
                    end
                    send(16'($urandom), 16'($urandom));
                end
                s_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    step();
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        m_ready = 1'b1;
        wait_drain(1000);
        check_int("rand_out_count", out_total - base, 10 * N);

        // Full backpressure: two frames fill both banks, the 17th waits.
        m_ready = 1'b0;
        base    = out_total;
        base_in = in_total;
        for (int i = 0; i < 2 * N; i++) send(16'($urandom), 16'($urandom));
        s_data  = {16'h0A17, 16'h0B17};
        s_valid = 1'b1;
        repeat (10) step();
        check("bp_s_ready", 65'(s_ready), 65'd0);
        check("bp_m_valid", 65'(m_valid), 65'd1);
        check_int("bp_in_count", in_total - base_in, 2 * N);
        check_int("bp_out_count", out_total - base, 0);
        m_ready = 1'b1;
        send(16'h0A17, 16'h0B17);
        s_valid = 1'b0;
        check_int("bp_accept17", in_total - base_in, 2 * N + 1);
        wait_drain(200);
        check_int("bp_drained", out_total - base, 2 * N);
        repeat (20) step();
        check("partial_held", 65'(m_valid), 65'd0);

        // Reset mid-frame: the partial frame now holds 5 samples.
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom));
        s_valid = 1'b0;
        check_int("pre_rst_fill", fill, 5);
        #2 rst = 1'b1;
        #2;
        check("mid_rst_s_ready", 65'(s_ready), 65'd0);
        check("mid_rst_m_valid", 65'(m_valid), 65'd0);
        check("mid_rst_m_axis", m_axis, 65'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("rel_rst_s_ready", 65'(s_ready), 65'd1);
        repeat (5) step();
        check("rel_rst_m_valid", 65'(m_valid), 65'd0);
        base = out_total;
        for (int i = 0; i < N; i++) send(16'($urandom), 16'($urandom));
        s_valid = 1'b0;
        wait_drain(100);
        check_int("rst_frame_count", out_total - base, N);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_input_reorder.md
Name: fft_input_reorder

Overview:
- Input stage placed directly upstream of the FFT core.
- Accepts a continuous stream of 16-bit signed complex samples (sample_t_int) in natural order.
- Sign-extends each component to 32 bits and groups samples into frames of N = 2^LOG2N points.
- Emits each frame as an axis_t stream in bit-reversed index order, with tlast on the final sample. A ping-pong double buffer lets one frame be written while the previous frame is read out.

Parameters:
- LOG2N, 10, log2 of frame length N. Legal range 2..12.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  32  sample_t_int: re[15:0] and im[15:0], two's complement.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept input.
- m_axis  out  65  axis_t: tdata.re[31:0], tdata.im[31:0], tlast.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts output.

Behaviour:
- Handshakes:
  - Input transfer occurs when s_valid & s_ready.
  - Output transfer occurs when m_valid & m_ready.
  - m_axis must hold stable while m_valid & !m_ready.
  - m_valid must not depend combinationally on m_ready.
- Storage:
  - Two banks, each N entries of sample_t.
  - Each bank has state EMPTY, FILLING or FULL (DRAINING while being read).
- Arithmetic:
  - tdata.re = {{16{s_data.re[15]}}, s_data.re}; im likewise.
  - No other arithmetic, no saturation.
- Write side:
  - Signals: wr_bank (1 bit) and wr_cnt (LOG2N bits).
  - s_ready = 1 when bank[wr_bank] is not FULL/DRAINING.
  - On each input transfer, write mem[wr_bank][wr_cnt].
  - When wr_cnt = N-1: mark the bank FULL, toggle wr_bank, wrap wr_cnt to 0.
- Read side:
  - Signals: rd_bank and rd_cnt.
  - Read address = bit-reverse of rd_cnt over LOG2N bits.
  - Reading starts when bank[rd_bank] is FULL.
  - tlast = 1 exactly when rd_cnt = N-1.
  - When the tlast sample transfers, the bank returns to EMPTY on the next edge, rd_bank toggles, and rd_cnt wraps to 0.
- Latency:
  - The first sample of a frame is presented on m_valid exactly 2 cycles after the edge accepting input sample N-1, provided the read side is idle.
- Throughput:
  - With m_ready held 1 and s_valid held 1, the block sustains one input and one output per cycle indefinitely.
  - No bubbles within or between frames once the pipeline is primed.
  - Implement this with a registered memory read plus a 2-entry output skid/holding stage.
- Boundary conditions:
  - Both banks FULL/DRAINING: s_ready = 0 until the draining bank's last sample transfers. s_ready rises no later than the 2nd cycle after that transfer.
  - A write to one bank and a read from the other in the same cycle are independent and both proceed.
  - The write pointer never enters a bank that is still draining.
  - A partial frame stays buffered indefinitely. Nothing is emitted until N samples have arrived.
- Reset (asynchronous, any time including mid-frame):
  - Outputs: m_valid = 0, m_axis = 0, s_ready = 0 while rst is high.
  - State: both banks EMPTY, wr_bank = rd_bank = 0, all counters 0.
  - Any partial or pending frame is discarded; memory contents are don't-care.
  - s_ready = 1 on the first edge after rst deasserts.

Test Plan:
- Bit-reverse order (LOG2N=3): feed re=0..7, im=-1..-8 with m_ready=1 -> output re order 0,4,2,6,1,5,3,7 with matching im 32'hFFFFFFFF, FFFFFFFB, FFFFFFFD, FFFFFFF9, FFFFFFFE, FFFFFFFA, FFFFFFFC, FFFFFFF8. tlast only on the 8th output (re=7). First m_valid 2 cycles after the 8th input is accepted.
- Sign extension: s_data.re=16'h8000, im=16'h7FFF -> tdata.re=32'hFFFF8000, tdata.im=32'h00007FFF.
- Full backpressure (LOG2N=3), m_ready=0:
  - 16 samples are accepted, then s_ready=0 and the 17th sample is held.
  - Raise m_ready -> frame 1 drains (8 beats), s_ready reasserts, and the 17th sample is accepted.
- Random m_ready (50%) over 10 frames -> output matches the bit-reversed model exactly, and m_axis is stable on every stalled cycle.
- Streaming throughput: 4 back-to-back frames with s_valid=m_ready=1 constant -> 32 outputs on 32 consecutive cycles, and s_ready never drops.
- Reset mid-frame: accept 5 samples, pulse rst for 1 cycle (asynchronous, mid-cycle) -> m_valid stays 0. The next 8 samples produce one correct frame with no residue from the aborted frame.
